// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: state encoding, header tag and header-word builder shared by the
// FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    PAD  = 2'd3
  } arb_state_t;

  localparam logic [7:0]  HDR_TAG   = 8'hA5;
  localparam int unsigned HDR_MAX_W = 64;

  // Tag in the top byte of a width-bit word, channel ID zero-extended below it.
  function automatic logic [HDR_MAX_W-1:0] build_hdr(input logic [3:0] ch_id,
                                                     input int unsigned width);
    logic [HDR_MAX_W-1:0] w_hdr;
    w_hdr = ({56'd0, HDR_TAG} << (width - 32'd8)) | {60'd0, ch_id};
    return w_hdr;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after the
// previous winner, returned both one-hot and as a binary index.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_last_grant,
  output logic [N-1:0]    o_gnt,
  output logic [ID_W-1:0] o_gnt_id
);

  logic            w_found;
  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;

  // Walk last_grant+1 .. last_grant+N (mod N); the first request seen wins.
  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int i = 1; i <= N; i++) begin
      w_sum    = {1'b0, i_last_grant} + (ID_W+1)'(i);
      w_idx    = (w_sum >= (ID_W+1)'(N)) ? ID_W'(w_sum - (ID_W+1)'(N)) : ID_W'(w_sum);
      o_gnt[w_idx] = i_req[w_idx] & ~w_found;
      o_gnt_id = (i_req[w_idx] & ~w_found) ? w_idx : o_gnt_id;
      w_found  = w_found | i_req[w_idx];
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter framing producer bursts (header, data, zero pad)
// onto the single write port of the packing FIFO.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int IN_WIDTH  = 16,
  parameter int PACK      = 16,
  parameter int MAX_BURST = 15
) (
  input  logic                     wr_clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [N_CH-1:0]          ch_valid,
  input  logic [N_CH*IN_WIDTH-1:0] ch_data,
  input  logic [N_CH-1:0]          ch_last,
  output logic [N_CH-1:0]          ch_ready,
  input  logic                     fifo_full,
  output logic                     o_wr_en,
  output logic [IN_WIDTH-1:0]      o_din,
  output logic [N_CH-1:0]          o_grant,
  output logic                     o_busy,
  output logic                     o_trunc
);

  localparam int ID_W = $clog2(N_CH);
  localparam int FC_W = $clog2(PACK);
  localparam int DC_W = $clog2(MAX_BURST + 1);

  arb_state_t          r_state, w_state_nxt;
  logic [N_CH-1:0]     r_gnt, w_arb_gnt;
  logic [ID_W-1:0]     r_gnt_id, r_last_grant, w_arb_id;
  logic [FC_W-1:0]     r_frame_cnt, w_fc_inc;
  logic [DC_W-1:0]     r_data_cnt;
  logic                r_busy, r_trunc;
  logic                w_any_req, w_sel_valid, w_sel_last, w_at_limit;
  logic                w_beat, w_burst_end, w_trunc;
  logic [IN_WIDTH-1:0] w_sel_data;
  logic [IN_WIDTH-1:0] w_ch_word [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign w_ch_word[k] = ch_data[k*IN_WIDTH +: IN_WIDTH];
  end

  rr_arbiter #(.N(N_CH)) u_rr (
    .i_req        (ch_valid),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_arb_gnt),
    .o_gnt_id     (w_arb_id)
  );

  assign w_any_req   = |ch_valid;
  assign w_sel_valid = ch_valid[r_gnt_id];
  assign w_sel_last  = ch_last[r_gnt_id];
  assign w_sel_data  = w_ch_word[r_gnt_id];
  assign w_at_limit  = (r_data_cnt == DC_W'(MAX_BURST - 1));
  assign w_beat      = (r_state == DATA) & w_sel_valid & ~fifo_full;
  assign w_burst_end = w_beat & (w_sel_last | w_at_limit);
  // A last word landing exactly on the limit is a normal end, not a truncation.
  assign w_trunc     = w_beat & ~w_sel_last & w_at_limit;
  assign w_fc_inc    = r_frame_cnt + FC_W'(1);

  // State register.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: a frame closes once the write count wraps to a PACK boundary.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_any_req ? HDR : IDLE;
      HDR:     w_state_nxt = fifo_full ? HDR : DATA;
      DATA: begin
        if (w_burst_end) begin
          w_state_nxt = (w_fc_inc == '0) ? IDLE : PAD;
        end else begin
          w_state_nxt = DATA;
        end
      end
      PAD:     w_state_nxt = (!fifo_full && (w_fc_inc == '0)) ? IDLE : PAD;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Write port and producer handshake, combinational for zero-cycle accept.
  always_comb begin
    o_wr_en  = 1'b0;
    o_din    = '0;
    ch_ready = '0;
    case (r_state)
      HDR: begin
        if (!fifo_full) begin
          o_wr_en = 1'b1;
          o_din   = IN_WIDTH'(build_hdr(4'(r_gnt_id), IN_WIDTH));
        end else begin
          o_wr_en = 1'b0;
        end
      end
      DATA: begin
        ch_ready = fifo_full ? '0 : r_gnt;
        if (w_beat) begin
          o_wr_en = 1'b1;
          o_din   = w_sel_data;
        end else begin
          o_wr_en = 1'b0;
        end
      end
      PAD:     o_wr_en = ~fifo_full;
      default: o_wr_en = 1'b0;
    endcase
  end

  // Counters, round-robin pointer and registered status outputs.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt  <= '0;
      r_data_cnt   <= '0;
      r_gnt_id     <= '0;
      r_last_grant <= ID_W'(N_CH - 1);
      r_gnt        <= '0;
      r_busy       <= 1'b0;
      r_trunc      <= 1'b0;
    end else if (clr) begin
      r_frame_cnt  <= '0;
      r_data_cnt   <= '0;
      r_gnt_id     <= '0;
      r_last_grant <= ID_W'(N_CH - 1);
      r_gnt        <= '0;
      r_busy       <= 1'b0;
      r_trunc      <= 1'b0;
    end else begin
      r_trunc <= w_trunc;
      r_busy  <= (w_state_nxt != IDLE);
      r_gnt   <= (w_state_nxt == IDLE) ? '0 : ((r_state == IDLE) ? w_arb_gnt : r_gnt);
      case (r_state)
        IDLE: begin
          r_frame_cnt <= '0;
          r_data_cnt  <= '0;
          if (w_any_req) begin
            r_gnt_id     <= w_arb_id;
            r_last_grant <= w_arb_id;
          end
        end
        HDR: begin
          if (!fifo_full) r_frame_cnt <= FC_W'(1);
        end
        DATA: begin
          if (w_beat) begin
            r_frame_cnt <= w_fc_inc;
            r_data_cnt  <= w_burst_end ? '0 : r_data_cnt + DC_W'(1);
          end
        end
        PAD: begin
          if (!fifo_full) r_frame_cnt <= w_fc_inc;
        end
        default: r_frame_cnt <= '0;
      endcase
    end
  end

  assign o_grant = r_gnt;
  assign o_busy  = r_busy;
  assign o_trunc = r_trunc;

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-side arbiter that shares the single write port of the async packing FIFO between `N_CH` pixel/line producers in the `wr_clk` domain. Each grant is framed as one header word (channel ID), up to `MAX_BURST` data words, and zero padding. The padding brings the frame to a multiple of the FIFO's pack ratio, so every packed output word belongs to exactly one channel. It sits directly in front of the FIFO's `i_wr_en`/`i_din` and consumes its `full` flag.

## Interface
- `N_CH`, 4: number of requesting channels, 2..16.
- `IN_WIDTH`, 16: word width; must be ≥ 16.
- `PACK`, 16: FIFO pack ratio (`OUT_WIDTH/IN_WIDTH`); must be a power of 2.
- `MAX_BURST`, 15: maximum data words per grant; must be ≥ 1.

- `wr_clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `clr`  in  1  synchronous clear, same effect as reset.
- `ch_valid`  in  N_CH  per-channel word valid.
- `ch_data`  in  N_CH*IN_WIDTH  per-channel word; channel k occupies bits [k*IN_WIDTH +: IN_WIDTH].
- `ch_last`  in  N_CH  marks the final word of a channel's packet.
- `ch_ready`  out  N_CH  per-channel accept.
- `fifo_full`  in  1  FIFO full flag.
- `o_wr_en`  out  1  FIFO write strobe.
- `o_din`  out  IN_WIDTH  FIFO write data.
- `o_grant`  out  N_CH  one-hot owner of the current frame; 0 in IDLE.
- `o_busy`  out  1  high when the FSM is not in IDLE.
- `o_trunc`  out  1  one-cycle pulse when a burst is cut at `MAX_BURST`.

## Operation
- **States** (`arb_state_t`): IDLE, HDR, DATA, PAD.
- **IDLE**
  - If any `ch_valid` is high, the round-robin arbiter picks the first valid channel, searching from `last_grant+1` modulo `N_CH`.
  - Register the one-hot grant and move to HDR.
  - No write occurs in this cycle.
- **HDR**
  - When `!fifo_full`: write header word `{8'hA5, ch_id zero-extended to IN_WIDTH-8}`, set `frame_cnt=1`, move to DATA.
  - When `fifo_full`: hold.
- **DATA**
  - `ch_ready[g] = !fifo_full`; all other `ch_ready` bits are 0.
  - A beat is `ch_valid[g] & ch_ready[g]`. On a beat, `o_wr_en=1` and `o_din=ch_data[g]`.
  - Each beat increments `frame_cnt` and `data_cnt`.
  - Valid gaps are allowed; the grant is held.
  - The burst ends on a beat with `ch_last[g]`, or a beat with `data_cnt==MAX_BURST-1`. The latter pulses `o_trunc`.
  - At burst end, go to IDLE if `(frame_cnt+1) % PACK == 0`, otherwise go to PAD.
  - After a truncation, the channel's remaining words continue in a later grant with a new header.
- **PAD**
  - Write 0 on each `!fifo_full` cycle until `frame_cnt % PACK == 0`, then go to IDLE.
- **Output rules**
  - `o_wr_en` is never high while `fifo_full=1`.
  - `o_din=0` whenever `o_wr_en=0`.
- **Arithmetic**
  - `frame_cnt` is `$clog2(PACK)` bits and wraps naturally; the PAD exit test is `frame_cnt==0`.
  - `data_cnt` is `$clog2(MAX_BURST+1)` bits.
- **Round-robin pointer**
  - `last_grant` updates on entry to HDR.
- **Reset / clr**
  - State becomes IDLE, all counters 0, `last_grant=N_CH-1` (so ch0 wins first).
  - All outputs are 0.
  - A frame in progress is abandoned without padding; `clr` is paired with a FIFO `clr`.

## Timing
- `o_wr_en`, `o_din`, and `ch_ready` are combinational from the state, `fifo_full`, and `ch_valid[g]`, giving zero-cycle accept-to-write.
- `o_grant`, `o_busy`, and `o_trunc` are registered.
- Request to header write: 2 cycles when not full (IDLE sample, then HDR).
- IDLE costs one cycle between frames, so back-to-back frames have one idle write cycle.
- `fifo_full` rising during DATA stalls the transfer: `ch_ready` drops in the same cycle and the producer holds its data.
- Simultaneous `ch_last` and truncation condition: treated as normal end, with no `o_trunc`.

## Structure
- **Package `fifo_arb_pkg`:** `arb_state_t`, `HDR_TAG=8'hA5`, and a header-build function.
- **Sub-module `rr_arbiter`** (parameter `N`):
  - Inputs: `req[N]`, `last_grant`.
  - Output: one-hot `gnt[N]` plus binary `gnt_id`.
  - Purely combinational.
- **Main module:** FSM, counters, datapath mux.

## Test plan
- **Single channel:** ch0 sends 3 words `0x1111..0x3333` with last on the third.
  - Expected: FIFO sees `0xA500, 0x1111, 0x2222, 0x3333`, then 12×`0x0000`.
  - Total 16 writes, `o_grant=4'b0001` throughout.
- **Aligned burst:** ch2 sends a 15-word packet.
  - Expected: header `0xA502` plus 15 data words, no PAD, return to IDLE immediately, `o_trunc=0`.
- **Contention:** ch1 and ch3 are both continuously valid.
  - Expected: grants alternate ch1, ch3, ch1, ch3; ch0 and ch2 are never granted; headers `0xA501`/`0xA503` alternate.
- **Truncation:** ch0 sends a 20-word packet.
  - Expected: first frame is header plus 15 words with an `o_trunc` pulse; second frame is header `0xA500`, 5 words, and 10 pad words.
- **Backpressure:** `fifo_full` is held high for 5 cycles mid-DATA.
  - Expected: `o_wr_en=0` and `ch_ready=0` for those cycles; no word lost or duplicated; the frame count still totals 16.
- **Reset/clr mid-operation:** `rst` asserted mid-PAD, then `clr` asserted mid-DATA.
  - Expected: outputs 0 immediately on `rst`; IDLE on the next edge after `clr`; the next grant goes to ch0 when all channels are valid.
